// File: rtl/core7_cpu_5_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core7_cpu_5_oci_dct_pkg
// Description : Shared constants and types for the cpu_5 OCI direct-branch
//               trace packer: record codes, sizing and the drain FSM states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package core7_cpu_5_oci_dct_pkg;

   // Largest packet the fixed-width ports can carry.
   localparam int DCT_MAX_DEPTH = 15;
   localparam int DCT_DATA_W    = 2 * DCT_MAX_DEPTH;
   localparam int DCT_CNT_W     = 4;
   localparam int DCT_PKT_W     = DCT_DATA_W + DCT_CNT_W;

   // Two-bit branch record codes.
   localparam logic [1:0] DCT_RSVD = 2'b00;
   localparam logic [1:0] DCT_NT   = 2'b01;
   localparam logic [1:0] DCT_TK   = 2'b10;
   localparam logic [1:0] DCT_EXC  = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ENDED = 2'd2
   } dct_state_t;

   // A record carries trace information unless it uses the reserved code.
   function automatic logic dct_code_valid(input logic [1:0] code);
      return code != DCT_RSVD;
   endfunction

endpackage : core7_cpu_5_oci_dct_pkg
`default_nettype wire

// File: rtl/core7_cpu_5_oci_dct_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : core7_cpu_5_oci_dct_out_reg
// Description : Single-entry valid/ready holding register for trace packets.
//               load_ok_o tells the producer the slot is free this cycle
//               (empty, or being drained by ready_i on this edge).
// Ports       : clk, reset      - clock, synchronous active-high reset
//               load_i, data_i  - write a new packet (only when load_ok_o)
//               ready_i         - consumer takes the held packet
//               valid_o, data_o - held packet
//               load_ok_o       - slot may be written this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module core7_cpu_5_oci_dct_out_reg
   import core7_cpu_5_oci_dct_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic [DCT_PKT_W-1:0] data_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [DCT_PKT_W-1:0] data_o,
   output logic                 load_ok_o
);

   logic                 valid_q;
   logic [DCT_PKT_W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         // A load on a draining edge replaces the departing packet in place.
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o   = valid_q;
   assign data_o    = data_q;
   assign load_ok_o = !valid_q || ready_i;

endmodule : core7_cpu_5_oci_dct_out_reg
`default_nettype wire

// File: rtl/core7_cpu_5_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module      : core7_cpu_5_oci_dct_packer
// Description : Packs 2-bit direct-branch records into a 2*DEPTH-bit
//               accumulator and emits full or flushed packets through a
//               valid/ready output register. Also runs the end-of-test drain
//               (RUN -> DRAIN -> ENDED) and exposes the live accumulator.
// Ports       : clk, reset                  - clock, sync active-high reset
//               in_valid, in_code, in_ready - record input handshake
//               flush                       - emit partial accumulator
//               pkt_valid/ready/data/count  - packet output handshake
//               dct_buffer, dct_count       - live accumulator observation
//               test_end_req                - request end-of-test drain
//               test_ending, test_has_ended - drain status
//               code_err                    - sticky reserved-code flag
// Revision    : 1.0 - initial release
// ============================================================================
module core7_cpu_5_oci_dct_packer
   import core7_cpu_5_oci_dct_pkg::*;
#(
   parameter int DEPTH = 15   // records per packet, 1..15
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [1:0]            in_code,
   output logic                  in_ready,
   input  logic                  flush,
   output logic                  pkt_valid,
   input  logic                  pkt_ready,
   output logic [DCT_DATA_W-1:0] pkt_data,
   output logic [DCT_CNT_W-1:0]  pkt_count,
   output logic [DCT_DATA_W-1:0] dct_buffer,
   output logic [DCT_CNT_W-1:0]  dct_count,
   input  logic                  test_end_req,
   output logic                  test_ending,
   output logic                  test_has_ended,
   output logic                  code_err
);

   localparam logic [DCT_CNT_W-1:0] c_DEPTH      = DCT_CNT_W'(DEPTH);
   localparam logic [DCT_CNT_W-1:0] c_DEPTH_LAST = DCT_CNT_W'(DEPTH - 1);

   dct_state_t             state_q, state_d;
   logic [DCT_DATA_W-1:0]  buf_q, buf_d;
   logic [DCT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   flush_pend_q, flush_pend_d;
   logic                   code_err_q, code_err_d;

   logic                   accept_w;
   logic                   rec_ok_w;
   logic [DCT_DATA_W-1:0]  ins_w;
   logic [DCT_DATA_W-1:0]  post_buf_w;
   logic [DCT_CNT_W-1:0]   post_cnt_w;
   logic                   flush_req_w;
   logic                   trigger_w;
   logic                   emit_w;
   logic                   load_ok_w;
   logic                   out_valid_w;
   logic [DCT_PKT_W-1:0]   out_data_w;

   // ------------------------------------------------------------------------
   // Input acceptance. Only registered state is used, so pkt_ready never
   // reaches in_ready combinationally. Refusing the record that would fill
   // the accumulator while a packet is still held guarantees the count can
   // never sit at DEPTH: any fill-completing accept is also an emit.
   // ------------------------------------------------------------------------
   assign in_ready = (state_q == ST_RUN) &&
                     !(out_valid_w && (cnt_q >= c_DEPTH_LAST));

   assign accept_w = in_valid && in_ready;
   assign rec_ok_w = accept_w && dct_code_valid(in_code);

   always_comb begin
      ins_w = '0;
      for (int i = 0; i < DCT_MAX_DEPTH; i++) begin
         if (rec_ok_w && (cnt_q == DCT_CNT_W'(i))) begin
            ins_w[2*i +: 2] = in_code;
         end
      end
   end

   // Accumulator as it would be after this cycle's accept, before any emit.
   assign post_buf_w = buf_q | ins_w;
   assign post_cnt_w = cnt_q + {{(DCT_CNT_W-1){1'b0}}, rec_ok_w};

   // A flush seen while the output is blocked is remembered in flush_pend_q.
   assign flush_req_w = flush_pend_q || (flush && (state_q != ST_ENDED));

   assign trigger_w = (post_cnt_w == c_DEPTH) ||
                      (flush_req_w && (post_cnt_w != '0)) ||
                      ((state_q == ST_DRAIN) && (post_cnt_w != '0));

   assign emit_w = trigger_w && load_ok_w;

   always_comb begin
      buf_d        = post_buf_w;
      cnt_d        = post_cnt_w;
      flush_pend_d = flush_req_w && (post_cnt_w != '0);
      code_err_d   = code_err_q || (accept_w && !dct_code_valid(in_code));
      if (emit_w) begin
         buf_d        = '0;
         cnt_d        = '0;
         flush_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q        <= '0;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         code_err_q   <= 1'b0;
      end else begin
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         code_err_q   <= code_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Drain FSM. DRAIN waits for both the accumulator and the output register
   // to empty so the last packet has actually left before ENDED is reported.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (test_end_req) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((cnt_q == '0) && !out_valid_w) begin
               state_d = ST_ENDED;
            end
         end
         ST_ENDED: begin
            state_d = ST_ENDED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   core7_cpu_5_oci_dct_out_reg u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load_i    (emit_w),
      .data_i    ({post_cnt_w, post_buf_w}),
      .ready_i   (pkt_ready),
      .valid_o   (out_valid_w),
      .data_o    (out_data_w),
      .load_ok_o (load_ok_w)
   );

   assign pkt_valid      = out_valid_w;
   assign pkt_count      = out_data_w[DCT_PKT_W-1:DCT_DATA_W];
   assign pkt_data       = out_data_w[DCT_DATA_W-1:0];
   assign dct_buffer     = buf_q;
   assign dct_count      = cnt_q;
   assign test_ending    = (state_q == ST_DRAIN);
   assign test_has_ended = (state_q == ST_ENDED);
   assign code_err       = code_err_q;

endmodule : core7_cpu_5_oci_dct_packer
`default_nettype wire

// File: tb/tb_core7_cpu_5_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core7_cpu_5_oci_dct_packer
// Description : Directed self-checking bench for the OCI direct-branch
//               trace packer. Inputs change 1ns after each rising edge and
//               outputs are read at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core7_cpu_5_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [1:0]  in_code;
   logic        in_ready;
   logic        flush;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [29:0] pkt_data;
   logic [3:0]  pkt_count;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_end_req;
   logic        test_ending;
   logic        test_has_ended;
   logic        code_err;

   int n_tests = 0;
   int n_fail  = 0;

   core7_cpu_5_oci_dct_packer #(.DEPTH(15)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_code        (in_code),
      .in_ready       (in_ready),
      .flush          (flush),
      .pkt_valid      (pkt_valid),
      .pkt_ready      (pkt_ready),
      .pkt_data       (pkt_data),
      .pkt_count      (pkt_count),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_end_req   (test_end_req),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended),
      .code_err       (code_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_code = 2'b00; flush = 1'b0;
      pkt_ready = 1'b0; test_end_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_valid got %b exp 0", pkt_valid); end
      n_tests++; if (pkt_data !== 30'h0 || pkt_count !== 4'd0) begin n_fail++; $display("FAIL rst_pkt got %h/%0d exp 0/0", pkt_data, pkt_count); end
      n_tests++; if (dct_buffer !== 30'h0 || dct_count !== 4'd0) begin n_fail++; $display("FAIL rst_acc got %h/%0d exp 0/0", dct_buffer, dct_count); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      n_tests++; if ({test_ending, test_has_ended, code_err} !== 3'b000) begin n_fail++; $display("FAIL rst_status got %b exp 000", {test_ending, test_has_ended, code_err}); end
   endtask

   task automatic test_fill();
      do_reset();
      pkt_ready = 1'b1; in_valid = 1'b1; in_code = 2'b10;
      for (int i = 1; i <= 14; i++) begin
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d] got %b exp 1", i, in_ready); end
         tick();
         n_tests++; if (dct_count !== 4'(i) || pkt_valid !== 1'b0) begin n_fail++; $display("FAIL fill_count[%0d] got %0d/%b exp %0d/0", i, dct_count, pkt_valid, i); end
      end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[15] got %b exp 1", in_ready); end
      tick();
      n_tests++; if (pkt_valid !== 1'b1 || pkt_data !== 30'h2AAAAAAA || pkt_count !== 4'd15) begin n_fail++; $display("FAIL fill_pkt got %b/%h/%0d exp 1/2aaaaaaa/15", pkt_valid, pkt_data, pkt_count); end
      n_tests++; if (dct_count !== 4'd0 || dct_buffer !== 30'h0) begin n_fail++; $display("FAIL fill_acc_clear got %h/%0d exp 0/0", dct_buffer, dct_count); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_no_bubble got %b exp 1", in_ready); end
      in_code = 2'b01;
      tick();
      in_valid = 1'b0;
      n_tests++; if (pkt_valid !== 1'b0 || dct_count !== 4'd1 || dct_buffer !== 30'h1) begin n_fail++; $display("FAIL fill_next got %b/%0d/%h exp 0/1/1", pkt_valid, dct_count, dct_buffer); end
   endtask

   task automatic test_flush();
      do_reset();
      pkt_ready = 1'b1; in_valid = 1'b1;
      in_code = 2'b01; tick();
      in_code = 2'b10; tick();
      in_code = 2'b11; tick();
      n_tests++; if (dct_buffer !== 30'h39 || dct_count !== 4'd3) begin n_fail++; $display("FAIL flush_acc got %h/%0d exp 39/3", dct_buffer, dct_count); end
      in_valid = 1'b0; flush = 1'b1;
      tick();
      n_tests++; if (pkt_valid !== 1'b1 || pkt_data !== 30'h39 || pkt_count !== 4'd3) begin n_fail++; $display("FAIL flush_pkt got %b/%h/%0d exp 1/39/3", pkt_valid, pkt_data, pkt_count); end
      n_tests++; if (dct_count !== 4'd0) begin n_fail++; $display("FAIL flush_clear got %0d exp 0", dct_count); end
      tick();
      flush = 1'b0;
      n_tests++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %b exp 0", pkt_valid); end
      tick();
      n_tests++; if (pkt_valid !== 1'b0 || dct_count !== 4'd0) begin n_fail++; $display("FAIL flush_empty2 got %b/%0d exp 0/0", pkt_valid, dct_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      pkt_ready = 1'b0; in_valid = 1'b1; in_code = 2'b01;
      for (int i = 1; i <= 15; i++) tick();
      n_tests++; if (pkt_valid !== 1'b1 || pkt_data !== 30'h15555555 || pkt_count !== 4'd15) begin n_fail++; $display("FAIL bp_pkt1 got %b/%h/%0d exp 1/15555555/15", pkt_valid, pkt_data, pkt_count); end
      for (int i = 1; i <= 14; i++) begin
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 1", i, in_ready); end
         tick();
      end
      n_tests++; if (dct_count !== 4'd14 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall got %0d/%b exp 14/0", dct_count, in_ready); end
      for (int i = 0; i < 3; i++) tick();
      n_tests++; if (dct_count !== 4'd14 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_acc got %0d/%b exp 14/0", dct_count, in_ready); end
      n_tests++; if (pkt_valid !== 1'b1 || pkt_data !== 30'h15555555 || pkt_count !== 4'd15) begin n_fail++; $display("FAIL bp_pkt_stable got %b/%h/%0d exp 1/15555555/15", pkt_valid, pkt_data, pkt_count); end
      pkt_ready = 1'b1;
      tick();
      n_tests++; if (pkt_valid !== 1'b0 || in_ready !== 1'b1 || dct_count !== 4'd14) begin n_fail++; $display("FAIL bp_release got %b/%b/%0d exp 0/1/14", pkt_valid, in_ready, dct_count); end
      tick();
      in_valid = 1'b0;
      n_tests++; if (pkt_valid !== 1'b1 || pkt_data !== 30'h15555555 || pkt_count !== 4'd15 || dct_count !== 4'd0) begin n_fail++; $display("FAIL bp_pkt2 got %b/%h/%0d/%0d exp 1/15555555/15/0", pkt_valid, pkt_data, pkt_count, dct_count); end
   endtask

   task automatic test_reserved();
      do_reset();
      pkt_ready = 1'b1; in_valid = 1'b1;
      in_code = 2'b01; tick();
      in_code = 2'b00; tick();
      n_tests++; if (dct_count !== 4'd1 || dct_buffer !== 30'h1 || code_err !== 1'b1) begin n_fail++; $display("FAIL rsvd_drop got %0d/%h/%b exp 1/1/1", dct_count, dct_buffer, code_err); end
      in_code = 2'b10; tick();
      in_valid = 1'b0;
      n_tests++; if (dct_count !== 4'd2 || dct_buffer !== 30'h9) begin n_fail++; $display("FAIL rsvd_next got %0d/%h exp 2/9", dct_count, dct_buffer); end
      tick();
      n_tests++; if (code_err !== 1'b1) begin n_fail++; $display("FAIL rsvd_sticky got %b exp 1", code_err); end
   endtask

   task automatic test_drain();
      do_reset();
      pkt_ready = 1'b1; in_valid = 1'b1; in_code = 2'b11;
      for (int i = 0; i < 5; i++) tick();
      in_valid = 1'b0; test_end_req = 1'b1;
      tick();
      test_end_req = 1'b0;
      n_tests++; if (test_ending !== 1'b1 || in_ready !== 1'b0 || dct_count !== 4'd5) begin n_fail++; $display("FAIL drain_enter got %b/%b/%0d exp 1/0/5", test_ending, in_ready, dct_count); end
      tick();
      n_tests++; if (pkt_valid !== 1'b1 || pkt_count !== 4'd5 || pkt_data !== 30'h3FF) begin n_fail++; $display("FAIL drain_pkt got %b/%0d/%h exp 1/5/3ff", pkt_valid, pkt_count, pkt_data); end
      tick();
      n_tests++; if (pkt_valid !== 1'b0 || test_has_ended !== 1'b0 || test_ending !== 1'b1) begin n_fail++; $display("FAIL drain_wait got %b/%b/%b exp 0/0/1", pkt_valid, test_has_ended, test_ending); end
      tick();
      n_tests++; if (test_has_ended !== 1'b1 || test_ending !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ended got %b/%b/%b exp 1/0/0", test_has_ended, test_ending, in_ready); end
      in_valid = 1'b1; in_code = 2'b10; flush = 1'b1; test_end_req = 1'b1;
      tick(); tick();
      in_valid = 1'b0; flush = 1'b0; test_end_req = 1'b0;
      n_tests++; if (test_has_ended !== 1'b1 || dct_count !== 4'd0 || pkt_valid !== 1'b0) begin n_fail++; $display("FAIL ended_ignore got %b/%0d/%b exp 1/0/0", test_has_ended, dct_count, pkt_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pkt_ready = 1'b0; in_valid = 1'b1; in_code = 2'b01;
      for (int i = 0; i < 22; i++) tick();
      n_tests++; if (pkt_valid !== 1'b1 || dct_count !== 4'd7) begin n_fail++; $display("FAIL rmid_setup got %b/%0d exp 1/7", pkt_valid, dct_count); end
      reset = 1'b1; in_valid = 1'b0;
      tick();
      n_tests++; if (pkt_valid !== 1'b0 || pkt_data !== 30'h0 || pkt_count !== 4'd0 || dct_buffer !== 30'h0 || dct_count !== 4'd0) begin n_fail++; $display("FAIL rmid_clear got %b/%h/%0d/%h/%0d exp all 0", pkt_valid, pkt_data, pkt_count, dct_buffer, dct_count); end
      reset = 1'b0; pkt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++; if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_pkt[%0d] got %b exp 0", i, pkt_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_flush();
      test_backpressure();
      test_reserved();
      test_drain();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_core7_cpu_5_oci_dct_packer
`default_nettype wire
